// File: rtl/timer_sequencer.sv
// Run/pause/load/done sequencer for an external 0..99 up/down counter: synchronised button
// pulses, a prescaled count tick and terminal-count wrap tracking.
module timer_sequencer #(
    parameter int TICK_DIV  = 25000000,
    parameter int MAX_WRAPS = 4
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_load,
    input  logic       dir_sw,
    input  logic [6:0] count_in,
    output logic       cnt_start,
    output logic       cnt_stop,
    output logic       cnt_up,
    output logic       cnt_load,
    output logic       cnt_reset,
    output logic       tick,
    output logic [2:0] state,
    output logic [3:0] wrap_count,
    output logic       alarm
);

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        RUN     = 3'b001,
        PAUSE   = 3'b010,
        LOADING = 3'b011,
        DONE    = 3'b100
    } state_t;

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TOP  = PW'(TICK_DIV - 1);
    localparam logic [3:0]    WRAP_LIMIT = 4'(MAX_WRAPS);

    logic [2:0]    btn_s;
    logic [1:0]    live_r;
    logic [2:0]    sync1_r, sync2_r, prev_r, arm_r, pulse_r;
    logic          start_s, stop_s, load_s, terminal_s, running_s, entering_s;
    state_t        state_r, next_state_s;
    logic [PW-1:0] presc_r, presc_next_s;
    logic [3:0]    wrap_r, wrap_next_s;
    logic          tick_r, up_r;
    logic          cnt_start_r, cnt_stop_r, cnt_load_r, cnt_reset_r, alarm_r;

    assign btn_s = {btn_load, btn_stop, btn_start};

    // Button synchronisers and rising-edge pulses; a button is armed only after it has been
    // seen low in a genuine post-reset sample, so a button held through reset release is ignored.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            live_r  <= 2'b00;
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
            prev_r  <= 3'b000;
            arm_r   <= 3'b000;
            pulse_r <= 3'b000;
        end else begin
            live_r  <= {live_r[0], 1'b1};
            sync1_r <= btn_s;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            arm_r   <= arm_r | (~sync2_r & {3{live_r[1]}});
            pulse_r <= sync2_r & ~prev_r & arm_r;
        end
    end

    assign stop_s  = pulse_r[1];
    assign load_s  = pulse_r[2] & ~pulse_r[1];
    assign start_s = pulse_r[0] & ~pulse_r[1] & ~pulse_r[2];

    // Next-state, wrap and prescaler decisions.
    always_comb begin
        next_state_s = state_r;
        wrap_next_s  = wrap_r;
        terminal_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_s)     next_state_s = RUN;
                else if (load_s) next_state_s = LOADING;
                else             next_state_s = IDLE;
            end
            RUN: begin
                terminal_s = tick_r && ((up_r && (count_in == 7'd99)) || (!up_r && (count_in == 7'd0)));
                if (terminal_s && (wrap_r != WRAP_LIMIT)) wrap_next_s = wrap_r + 4'd1;
                else                                      wrap_next_s = wrap_r;
                if (terminal_s && (wrap_next_s == WRAP_LIMIT)) next_state_s = DONE;
                else if (stop_s)                               next_state_s = PAUSE;
                else if (load_s)                               next_state_s = LOADING;
                else                                           next_state_s = RUN;
            end
            PAUSE: begin
                if (start_s)     next_state_s = RUN;
                else if (load_s) next_state_s = LOADING;
                else             next_state_s = PAUSE;
            end
            LOADING: begin
                if (tick_r) next_state_s = PAUSE;
                else        next_state_s = LOADING;
            end
            DONE: begin
                if (start_s) begin
                    next_state_s = IDLE;
                    wrap_next_s  = 4'd0;
                end else begin
                    next_state_s = DONE;
                    wrap_next_s  = wrap_r;
                end
            end
            default: begin
                next_state_s = IDLE;
                wrap_next_s  = 4'd0;
            end
        endcase

        running_s  = (next_state_s == state_r) && ((state_r == RUN) || (state_r == LOADING));
        entering_s = (next_state_s != state_r) && ((next_state_s == RUN) || (next_state_s == LOADING));
        if (!running_s)                presc_next_s = '0;
        else if (presc_r == PRESC_TOP) presc_next_s = '0;
        else                           presc_next_s = presc_r + PW'(1);
    end

    // State, prescaler, direction latch and registered output decode.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            presc_r     <= '0;
            tick_r      <= 1'b0;
            wrap_r      <= 4'd0;
            up_r        <= 1'b1;
            cnt_start_r <= 1'b0;
            cnt_stop_r  <= 1'b1;
            cnt_load_r  <= 1'b0;
            cnt_reset_r <= 1'b1;
            alarm_r     <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            presc_r     <= presc_next_s;
            tick_r      <= running_s && (presc_next_s == PRESC_TOP);
            wrap_r      <= wrap_next_s;
            up_r        <= entering_s ? dir_sw : up_r;
            cnt_start_r <= (next_state_s == RUN) || (next_state_s == LOADING);
            cnt_stop_r  <= !((next_state_s == RUN) || (next_state_s == LOADING));
            cnt_load_r  <= (next_state_s == LOADING);
            cnt_reset_r <= (next_state_s == IDLE) || (next_state_s == DONE);
            alarm_r     <= (next_state_s == DONE);
        end
    end

    assign state      = state_r;
    assign tick       = tick_r;
    assign wrap_count = wrap_r;
    assign cnt_up     = up_r;
    assign cnt_start  = cnt_start_r;
    assign cnt_stop   = cnt_stop_r;
    assign cnt_load   = cnt_load_r;
    assign cnt_reset  = cnt_reset_r;
    assign alarm      = alarm_r;

endmodule

// File: tb/tb_timer_sequencer.sv
// Randomised bench for timer_sequencer against a cycle-indexed behavioural model
// (button press timing from sample history, tick from edges elapsed since entry).
module tb_timer_sequencer;

    localparam int TD = 4;
    localparam int MW = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LOADING = 3, M_DONE = 4;

    logic       Clk = 1'b0;
    logic       reset;
    logic       btn_start, btn_stop, btn_load, dir_sw;
    logic [6:0] count_in;
    logic       cnt_start, cnt_stop, cnt_up, cnt_load, cnt_reset, tick, alarm;
    logic [2:0] state;
    logic [3:0] wrap_count;

    timer_sequencer #(.TICK_DIV(TD), .MAX_WRAPS(MW)) dut (
        .Clk(Clk), .reset(reset),
        .btn_start(btn_start), .btn_stop(btn_stop), .btn_load(btn_load),
        .dir_sw(dir_sw), .count_in(count_in),
        .cnt_start(cnt_start), .cnt_stop(cnt_stop), .cnt_up(cnt_up),
        .cnt_load(cnt_load), .cnt_reset(cnt_reset), .tick(tick),
        .state(state), .wrap_count(wrap_count), .alarm(alarm)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: mode, entry edge of the current RUN/LOADING stay, wraps, direction, tick.
    int       m_mode, m_entry, m_wraps, m_k;
    bit       m_up, m_tick;
    bit [2:0] hist[$];
    int       first_low[3];
    int       done_seen = 0, tick_seen = 0;

    function automatic bit samp(int j, int b);
        if (j >= 0 && j < hist.size()) return hist[j][b];
        return 1'b0;
    endfunction

    function automatic bit pressed(int k, int b);
        bit armed;
        armed = (first_low[b] >= 0) && (first_low[b] <= k - 4);
        return samp(k - 3, b) && !samp(k - 4, b) && armed;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_entry = 0; m_wraps = 0; m_k = 0;
        m_up = 1'b1; m_tick = 1'b0;
        hist.delete();
        for (int b = 0; b < 3; b++) first_low[b] = -1;
    endtask

    task automatic enter(input int mode);
        m_mode  = mode;
        m_entry = m_k;
        m_up    = dir_sw;
    endtask

    task automatic model_step();
        bit p_start, p_stop, p_load, term, run_like;
        bit [2:0] s;
        s = {btn_load, btn_stop, btn_start};
        hist.push_back(s);
        for (int b = 0; b < 3; b++)
            if (!s[b] && first_low[b] < 0) first_low[b] = m_k;
        p_stop  = pressed(m_k, 1);
        p_load  = pressed(m_k, 2) && !p_stop;
        p_start = pressed(m_k, 0) && !p_stop && !p_load;
        case (m_mode)
            M_IDLE:  if (p_start) enter(M_RUN); else if (p_load) enter(M_LOADING);
            M_RUN: begin
                term = m_tick && ((m_up && count_in == 7'd99) || (!m_up && count_in == 7'd0));
                if (term) m_wraps = (m_wraps < MW) ? m_wraps + 1 : MW;
                if (term && m_wraps == MW) m_mode = M_DONE;
                else if (p_stop)           m_mode = M_PAUSE;
                else if (p_load)           enter(M_LOADING);
            end
            M_PAUSE:   if (p_start) enter(M_RUN); else if (p_load) enter(M_LOADING);
            M_LOADING: if (m_tick) m_mode = M_PAUSE;
            M_DONE:    if (p_start) begin m_mode = M_IDLE; m_wraps = 0; end
            default:   m_mode = M_IDLE;
        endcase
        run_like = (m_mode == M_RUN) || (m_mode == M_LOADING);
        m_tick   = run_like && (((m_k - m_entry) % TD) == TD - 1);
        m_k++;
    endtask

    task automatic compare_all(input string ctx);
        bit run_like;
        run_like = (m_mode == M_RUN) || (m_mode == M_LOADING);
        check({ctx, ".state"},     32'(state),      32'(m_mode));
        check({ctx, ".tick"},      32'(tick),       32'(m_tick));
        check({ctx, ".wrap"},      32'(wrap_count), 32'(m_wraps));
        check({ctx, ".alarm"},     32'(alarm),      32'(m_mode == M_DONE));
        check({ctx, ".cnt_start"}, 32'(cnt_start),  32'(run_like));
        check({ctx, ".cnt_stop"},  32'(cnt_stop),   32'(!run_like));
        check({ctx, ".cnt_load"},  32'(cnt_load),   32'(m_mode == M_LOADING));
        check({ctx, ".cnt_reset"}, 32'(cnt_reset),  32'((m_mode == M_IDLE) || (m_mode == M_DONE)));
        check({ctx, ".cnt_up"},    32'(cnt_up),     32'(m_up));
    endtask

    initial begin
        bit in_reset;
        int rst_hold;
        int r;
        reset = 1'b1; btn_start = 1'b0; btn_stop = 1'b0; btn_load = 1'b0;
        dir_sw = 1'b1; count_in = 7'd0;
        model_reset();
        #1;
        compare_all("por");
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        reset = 1'b0;
        in_reset = 1'b0;
        rst_hold = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc != 0) @(negedge Clk);
            if (in_reset) begin
                if (rst_hold == 0) begin reset = 1'b0; in_reset = 1'b0; end
                else rst_hold--;
            end else if ($urandom_range(0, 299) == 0) begin
                #1 reset = 1'b1;
                model_reset();
                #1 compare_all("async_rst");
                in_reset = 1'b1;
                rst_hold = $urandom_range(0, 2);
            end
            if ($urandom_range(0, 7)  == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 19) == 0) btn_stop  = ~btn_stop;
            if ($urandom_range(0, 39) == 0) btn_load  = ~btn_load;
            if ($urandom_range(0, 9)  == 0) dir_sw    = ~dir_sw;
            r = $urandom_range(0, 9);
            if (r < 4)      count_in = 7'd99;
            else if (r < 8) count_in = 7'd0;
            else            count_in = 7'($urandom_range(1, 98));
            @(posedge Clk);
            if (!in_reset) model_step();
            #1;
            if (!in_reset) begin
                compare_all("run");
                if (alarm === 1'b1) done_seen++;
                if (tick === 1'b1) tick_seen++;
            end
        end

        check("done_reached", 32'(done_seen > 0), 32'd1);
        check("tick_seen",    32'(tick_seen > 0), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
